lfsr_spawn_gen: RTL and testbench

- Parametrised pseudo-random source and obstacle-spawn scheduler for the game core.
- A Fibonacci LFSR of configurable width and taps is stepped by an internal prescaler tick. The jump button can optionally be mixed in as entropy.
- A seed can be reloaded at run time, and an all-zero lock-up state is guarded against.
- A small FSM turns the random value into a randomised gap, in ticks, between cactus spawn pulses consumed by the obstacle generator.

---
 rtl/lfsr_spawn_gen.sv | 112 +++++++++++
 tb/tb_lfsr_spawn_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_spawn_gen.sv
// Pseudo-random source (Fibonacci LFSR stepped by a prescaler tick) and
// obstacle-spawn scheduler producing randomised gaps between spawn pulses.
module lfsr_spawn_gen #(
  parameter int unsigned      WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = 5'b10010,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
  parameter int unsigned      DIV      = 1256250,
  parameter int unsigned      OUT_W    = 5,
  parameter int unsigned      MIN_GAP  = 2,
  parameter int unsigned      GAP_BITS = 2,
  parameter bit               MIX_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             entropy_in,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  output logic [OUT_W-1:0] random_out,
  output logic             rnd_valid,
  output logic             spawn,
  output logic             busy
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned GAP_W = $clog2(MIN_GAP + (1 << GAP_BITS)) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_FIRE
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             tick, step, fb;

  assign tick    = en && (cnt_q == DIV_LAST);
  assign fb      = (^(lfsr_q & TAPS)) ^ (MIX_EN & entropy_in);
  assign shifted = {lfsr_q[WIDTH-2:0], fb};

  // Prescaler and LFSR next state; a seed load beats a tick and restarts the prescaler.
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    step   = 1'b0;
    if (seed_load) begin
      lfsr_d = (seed_val == '0) ? SEED : seed_val;
      cnt_d  = '0;
    end else if (tick) begin
      lfsr_d = (shifted == '0) ? SEED : shifted;
      cnt_d  = '0;
      step   = 1'b1;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Spawn scheduler; dropping en always parks the FSM in IDLE.
  always_comb begin
    fsm_d = fsm_q;
    gap_d = gap_q;
    if (!en) begin
      fsm_d = S_IDLE;
    end else begin
      case (fsm_q)
        S_IDLE: fsm_d = S_LOAD;
        S_LOAD: begin
          gap_d = GAP_W'(MIN_GAP) + GAP_W'(lfsr_q[GAP_BITS-1:0]);
          fsm_d = S_COUNT;
        end
        S_COUNT: begin
          if (seed_load) begin
            fsm_d = S_LOAD;
          end else if (tick) begin
            if (gap_q == GAP_W'(1)) fsm_d = S_FIRE;
            else                    gap_d = gap_q - GAP_W'(1);
          end
        end
        S_FIRE:  fsm_d = S_LOAD;
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= S_IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      gap_q      <= '0;
      random_out <= SEED[OUT_W-1:0];
      rnd_valid  <= 1'b0;
      spawn      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      random_out <= lfsr_d[OUT_W-1:0];
      rnd_valid  <= step;
      spawn      <= (fsm_d == S_FIRE);
      busy       <= (fsm_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_lfsr_spawn_gen.sv
// Bench for lfsr_spawn_gen: two instances (fast DIV=1 without mixing, DIV=4
// with mixing) checked every cycle against a tick-level behavioural model.
module tb_lfsr_spawn_gen;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_COUNT = 2;
  localparam int P_FIRE  = 3;

  logic       clk = 1'b0;
  logic       rst_n, en, ent, sl;
  logic [4:0] sv;
  logic [4:0] ro_a, ro_b;
  logic       rv_a, rv_b, sp_a, sp_b, bz_a, bz_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  int divs[2] = '{1, 4};
  int mixs[2] = '{0, 1};
  int m_st[2], m_cnt[2], m_gap[2], m_ph[2], m_ro[2], m_rv[2], m_sp[2], m_bz[2];
  int exp_seq[5] = '{2, 5, 10, 21, 11};

  always #5 clk = ~clk;

  lfsr_spawn_gen #(.DIV(1), .MIX_EN(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .entropy_in(ent), .seed_load(sl),
    .seed_val(sv), .random_out(ro_a), .rnd_valid(rv_a), .spawn(sp_a), .busy(bz_a)
  );

  lfsr_spawn_gen #(.DIV(4), .MIX_EN(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .entropy_in(ent), .seed_load(sl),
    .seed_val(sv), .random_out(ro_b), .rnd_valid(rv_b), .spawn(sp_b), .busy(bz_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one clock edge of instance i, written in terms of ticks and gap budgets.
  task automatic model_edge(input int i);
    bit tick;
    int nph, nxt, stepped;
    if (!rst_n) begin
      m_st[i] = 1; m_cnt[i] = 0; m_gap[i] = 0; m_ph[i] = P_IDLE;
      m_ro[i] = 1; m_rv[i] = 0; m_sp[i] = 0; m_bz[i] = 0;
      return;
    end
    tick = en && (m_cnt[i] == divs[i] - 1);
    nph  = m_ph[i];
    if (!en) nph = P_IDLE;
    else if (m_ph[i] == P_IDLE) nph = P_LOAD;
    else if (m_ph[i] == P_LOAD) begin
      m_gap[i] = 2 + (m_st[i] % 4);
      nph = P_COUNT;
    end else if (m_ph[i] == P_COUNT) begin
      if (sl) nph = P_LOAD;
      else if (tick && m_gap[i] == 1) nph = P_FIRE;
      else if (tick) m_gap[i] = m_gap[i] - 1;
    end else nph = P_LOAD;
    stepped = 0;
    if (sl) begin
      m_st[i]  = (sv == 0) ? 1 : int'(sv);
      m_cnt[i] = 0;
    end else if (tick) begin
      nxt = (m_st[i] * 2) % 32
          + (($countones(m_st[i] & 'h12) + (mixs[i] != 0 ? int'(ent) : 0)) % 2);
      m_st[i]  = (nxt == 0) ? 1 : nxt;
      m_cnt[i] = 0;
      stepped  = 1;
    end else if (en) begin
      m_cnt[i] = m_cnt[i] + 1;
    end
    m_ph[i] = nph;
    m_ro[i] = m_st[i];
    m_rv[i] = stepped;
    m_sp[i] = (nph == P_FIRE) ? 1 : 0;
    m_bz[i] = (nph != P_IDLE) ? 1 : 0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_edge(i);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a.random_out", int'(ro_a), m_ro[0]);
      chk("a.rnd_valid",  int'(rv_a), m_rv[0]);
      chk("a.spawn",      int'(sp_a), m_sp[0]);
      chk("a.busy",       int'(bz_a), m_bz[0]);
      chk("b.random_out", int'(ro_b), m_ro[1]);
      chk("b.rnd_valid",  int'(rv_b), m_rv[1]);
      chk("b.spawn",      int'(sp_b), m_sp[1]);
      chk("b.busy",       int'(bz_b), m_bz[1]);
    end
  end

  // Advance to a negedge where instance b sits in COUNT (optionally in a tick cycle).
  task automatic wait_b(input string name, input bit need_count, input bit need_tick);
    int guard = 0;
    while (!((!need_count || m_ph[1] == P_COUNT) && (!need_tick || m_cnt[1] == 3))
           && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) chk({name, ".timeout"}, 0, 1);
  endtask

  initial begin
    int first;
    int held;
    rst_n = 1'b0; en = 1'b0; ent = 1'b0; sl = 1'b0; sv = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("reset.random_out_a", int'(ro_a), 1);
    chk("reset.random_out_b", int'(ro_b), 1);
    chk("reset.busy_b", int'(bz_b), 0);
    chk("reset.rnd_valid_a", int'(rv_a), 0);

    // Free-running sequence and first spawn timing
    rst_n = 1'b1; en = 1'b1;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 5) chk("seq.random_out_a", int'(ro_a), exp_seq[k-1]);
      if (k == 31) chk("period.random_out_a", int'(ro_a), 1);
      if (k == 13) chk("first_spawn.width", int'(sp_b), 0);
      if (sp_b && first == 0) first = k;
    end
    chk("first_spawn.edge", first, 12);

    // Seed load colliding with a tick during COUNT
    wait_b("collide", 1'b1, 1'b1);
    sl = 1'b1; sv = 5'b10000;
    @(negedge clk);
    sl = 1'b0;
    chk("collide.random_out_b", int'(ro_b), 16);
    chk("collide.rnd_valid_b", int'(rv_b), 0);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sp_b && first == 0) first = k;
    end
    chk("collide.spawn_edge", first, 8);

    // Zero seed falls back to SEED; entropy flips the feedback bit
    sl = 1'b1; sv = '0;
    @(negedge clk);
    sl = 1'b0;
    chk("zero_seed.random_out_b", int'(ro_b), 1);
    chk("zero_seed.random_out_a", int'(ro_a), 1);
    wait_b("entropy", 1'b0, 1'b1);
    ent = 1'b1;
    @(negedge clk);
    ent = 1'b0;
    chk("entropy.random_out_b", int'(ro_b), 3);

    // Lock-up guard: 10000 with entropy would step to all-zero
    sl = 1'b1; sv = 5'b10000;
    @(negedge clk);
    sl = 1'b0;
    wait_b("lockup", 1'b0, 1'b1);
    ent = 1'b1;
    @(negedge clk);
    ent = 1'b0;
    chk("lockup.random_out_b", int'(ro_b), 1);
    chk("lockup.rnd_valid_b", int'(rv_b), 1);

    // Enable gating mid-gap
    wait_b("gate", 1'b1, 1'b0);
    held = m_ro[1];
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("gate.busy_b", int'(bz_b), 0);
      chk("gate.spawn_b", int'(sp_b), 0);
    end
    chk("gate.random_out_b", int'(ro_b), held);
    en = 1'b1;
    @(negedge clk);
    chk("gate.reload_busy_b", int'(bz_b), 1);
    repeat (30) @(negedge clk);

    // Reset in the middle of a gap
    wait_b("midreset", 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset.random_out_b", int'(ro_b), 1);
    chk("midreset.busy_b", int'(bz_b), 0);
    chk("midreset.spawn_b", int'(sp_b), 0);
    chk("midreset.rnd_valid_a", int'(rv_a), 0);
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
